score_display_mux: RTL



---
 rtl/score_disp_pkg.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/score_display_mux.sv | 98 +++++++++
 3 files changed

// File: rtl/score_disp_pkg.sv
// Shared types, glyph table and helpers for the multiplexed seven-segment score driver.
package score_disp_pkg;

  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  // Active-high glyphs, bit order g..a
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, BIN_W steps per conversion.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   bcd_r, bcd_adj;
  logic [BIN_W-1:0]   sr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) cnt <= CNT_W'(BIN_W);
      else if (state == CONV)     cnt <= cnt - 1'b1;
    end
  end

  // Datapath: only meaningful between an accepted start and done
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      bcd_r <= '0;
      sr    <= bin;
    end else if (state == CONV) begin
      {bcd_r, sr} <= {bcd_adj, sr} << 1;
    end
  end

  assign bcd  = bcd_r;
  assign busy = (state != IDLE);
  assign done = (state == COMMIT);

endmodule

// File: rtl/score_display_mux.sv
// Score-to-BCD conversion plus time-multiplexed seven-segment scan with registered AN/SEG.
// Define SCORE_DISP_LZB_EN to blank leading zeros (digit 0 always shown).
module score_display_mux
  import score_disp_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int BIN_W          = 14,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  score,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_in,
  output logic              busy,
  output logic              ovf,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN
);

  localparam int          BCD_W  = DIGITS * 4;
  localparam int          PRE_W  = $clog2(SCAN_DIV);
  localparam int          IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIMIT  = pow10(DIGITS);
  localparam logic [63:0] SATV   = LIMIT - 64'd1;
  localparam logic [7:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic              sat, ovf_pend, done;
  logic [BIN_W-1:0]  bin_sat;
  logic [BCD_W-1:0]  bcd, disp, disp_nxt;
  logic [PRE_W-1:0]  pre, pre_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              pre_term, blank;
  logic [3:0]        digit;
  logic [7:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;

  // Scores beyond the display range clamp to all nines
  assign sat     = (64'(score) >= LIMIT);
  assign bin_sat = sat ? SATV[BIN_W-1:0] : score;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .bin   (bin_sat),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (load && !busy) ovf_pend <= sat;
  end

  // Outputs are built from next-state values so AN/SEG line up with the register update
  always_comb begin
    pre_term = (pre == PRE_W'(SCAN_DIV - 1));
    pre_nxt  = pre_term ? '0 : pre + 1'b1;
    idx_nxt  = idx;
    if (pre_term) idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    disp_nxt = done ? bcd : disp;
    digit    = '0;
    blank    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        digit = disp_nxt[4*i +: 4];
`ifdef SCORE_DISP_LZB_EN
        blank = (i != 0) && ((disp_nxt >> (4*i)) == '0);
`endif
      end
    end
    seg_nxt = {dp_in[idx_nxt], blank ? GLYPH_BLANK : seg_encode(digit)};
    an_nxt  = DIGITS'(1) << idx_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      idx  <= '0;
      disp <= '0;
      ovf  <= 1'b0;
      SEG  <= SEG_OFF;
      AN   <= AN_OFF;
    end else begin
      pre  <= pre_nxt;
      idx  <= idx_nxt;
      disp <= disp_nxt;
      if (done) ovf <= ovf_pend;
      SEG  <= seg_nxt ^ SEG_OFF;
      AN   <= an_nxt ^ AN_OFF;
    end
  end

endmodule
